// File: rtl/muldiv_iter_pkg.sv
// rtl/muldiv_iter_pkg.sv - shared opcodes, FSM state codes and helpers for muldiv_iter
package muldiv_iter_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_MUL = 4'd8;
    localparam logic [3:0] ALU_DIV = 4'd9;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    function automatic logic is_md_op(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// rtl/muldiv_signfix.sv - conditional two's-complement negate; yields |x| when neg is the sign bit
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);

    assign res = neg ? (~val + WIDTH'(1)) : val;

endmodule

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative one-bit-per-cycle signed/unsigned multiply and divide unit
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALUop,
    input  logic             ifunsigned,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic             Zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo;
    logic [WIDTH:0]   opnd;
    logic             op_div, neg_res, neg_rem;

    logic             accept, div_in, b_zero, sgn_a, sgn_b, last_step;
    logic [WIDTH:0]   mag_a, mag_b;

    assign div_in    = (ALUop == ALU_DIV);
    assign b_zero    = (B == '0);
    assign accept    = (state == MD_IDLE) && start && !flush && is_md_op(ALUop);
    assign sgn_a     = !ifunsigned && A[WIDTH-1];
    assign sgn_b     = !ifunsigned && B[WIDTH-1];
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    // One extra magnitude bit keeps |MIN| representable for signed operands.
    muldiv_signfix #(.WIDTH(WIDTH + 1)) u_abs_a (.val({sgn_a, A}), .neg(sgn_a), .res(mag_a));
    muldiv_signfix #(.WIDTH(WIDTH + 1)) u_abs_b (.val({sgn_b, B}), .neg(sgn_b), .res(mag_b));

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, res_hi, res_lo;

    muldiv_signfix #(.WIDTH(2 * WIDTH)) u_fix_prod (.val({acc_hi, acc_lo}), .neg(neg_res), .res(prod_fix));
    muldiv_signfix #(.WIDTH(WIDTH))     u_fix_quot (.val(acc_lo), .neg(neg_res), .res(quot_fix));
    muldiv_signfix #(.WIDTH(WIDTH))     u_fix_rem  (.val(acc_hi), .neg(neg_rem), .res(rem_fix));

    assign res_hi = op_div ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo = op_div ? quot_fix : prod_fix[WIDTH-1:0];

    // Shift-add multiply step and restoring shift-subtract divide step.
    logic [WIDTH:0]   add_sum, shifted;
    logic [WIDTH-1:0] diff, step_hi, step_lo;
    logic             ge;

    always_comb begin
        add_sum = {1'b0, acc_hi} + (acc_lo[0] ? opnd : '0);
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        ge      = (shifted >= opnd);
        diff    = shifted[WIDTH-1:0] - opnd[WIDTH-1:0];
        if (op_div) begin
            step_hi = ge ? diff : shifted[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], ge};
        end else begin
            step_hi = add_sum[WIDTH:1];
            step_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = MD_IDLE;
        end else begin
            case (state)
                MD_IDLE: if (accept) state_nxt = (div_in && b_zero) ? MD_DONE : MD_CALC;
                MD_CALC: if (last_step) state_nxt = MD_FIX;
                MD_FIX:  state_nxt = MD_DONE;
                MD_DONE: state_nxt = MD_IDLE;
                default: state_nxt = MD_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == MD_CALC) || (state == MD_FIX);
        done = (state == MD_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            opnd        <= '0;
            op_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
            Zero        <= 1'b1;
        end else if (accept) begin
            cnt     <= '0;
            op_div  <= div_in;
            neg_res <= sgn_a ^ sgn_b;
            neg_rem <= sgn_a;
            acc_hi  <= '0;
            opnd    <= div_in ? mag_b : mag_a;
            acc_lo  <= div_in ? mag_a[WIDTH-1:0] : mag_b[WIDTH-1:0];
            if (div_in && b_zero) begin
                hi          <= A;
                lo          <= '1;
                div_by_zero <= 1'b1;
                Zero        <= 1'b0;
            end
        end else if (state == MD_CALC && !flush) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + CNT_W'(1);
        end else if (state == MD_FIX && !flush) begin
            hi          <= res_hi;
            lo          <= res_lo;
            div_by_zero <= 1'b0;
            Zero        <= (res_lo == '0);
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// tb/tb_muldiv_iter.sv - self-checking bench for muldiv_iter (WIDTH=32)
module tb_muldiv_iter;
    import muldiv_iter_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   ALUop = ALU_ADD;
    logic         ifunsigned = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         flush = 1'b0;
    logic         busy, done, div_by_zero, Zero;
    logic [W-1:0] hi, lo;

    muldiv_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ALUop(ALUop), .ifunsigned(ifunsigned),
        .A(A), .B(B), .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero), .Zero(Zero)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    // Reference: plain 64-bit integer arithmetic (SV division truncates toward zero).
    task automatic model(input logic div, input logic uns, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output logic ed);
        longint sa, sb, p, q, r;
        if (div && b == 0) begin
            eh = a; el = 32'hFFFF_FFFF; ed = 1'b1;
            return;
        end
        ed = 1'b0;
        if (uns) begin
            sa = longint'({32'b0, a}); sb = longint'({32'b0, b});
        end else begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
        end
        if (!div) begin
            p = sa * sb;
            eh = p[63:32]; el = p[31:0];
        end else begin
            q = sa / sb; r = sa % sb;
            el = q[31:0]; eh = r[31:0];
        end
    endtask

    // lat = cycle number (1 = first cycle after the accept edge) in which done is seen.
    task automatic run_op(input logic [3:0] op, input logic uns, input logic [31:0] a,
                          input logic [31:0] b, output int lat, output int bcnt);
        @(negedge clk);
        ALUop = op; ifunsigned = uns; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; bcnt = 0;
        while (!done && lat < 200) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic        uns;
        logic [31:0] a, b, eh, el;
        logic        ed;
        int          lat;
    } vec_t;

    vec_t vt[13];

    initial begin
        int lat, bcnt, dn, seen, bad;
        logic [31:0] eh, el, h, l;
        logic ed, rdiv, runs;
        logic [31:0] ra, rb;

        vt[0]  = '{ALU_MUL, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
        vt[1]  = '{ALU_DIV, 1'b0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
        vt[2]  = '{ALU_MUL, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
        vt[3]  = '{ALU_DIV, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
        vt[4]  = '{ALU_DIV, 1'b1, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1, 1};
        vt[5]  = '{ALU_DIV, 1'b1, 32'h0000000A, 32'h00000003, 32'h00000001, 32'h00000003, 1'b0, 34};
        vt[6]  = '{ALU_DIV, 1'b0, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
        vt[7]  = '{ALU_MUL, 1'b0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34};
        vt[8]  = '{ALU_MUL, 1'b1, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0, 34};
        vt[9]  = '{ALU_DIV, 1'b0, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 1};
        vt[10] = '{ALU_DIV, 1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34};
        vt[11] = '{ALU_MUL, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};
        vt[12] = '{ALU_DIV, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, 34};

        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_dbz", div_by_zero, 0);
        check("reset_zero", Zero, 1);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            run_op(vt[i].op, vt[i].uns, vt[i].a, vt[i].b, lat, bcnt);
            check($sformatf("vec%0d_hi", i), hi, vt[i].eh);
            check($sformatf("vec%0d_lo", i), lo, vt[i].el);
            check($sformatf("vec%0d_dbz", i), div_by_zero, vt[i].ed);
            check($sformatf("vec%0d_zero", i), Zero, vt[i].el == 0);
            check($sformatf("vec%0d_latency", i), lat, vt[i].lat);
            check($sformatf("vec%0d_busy_cycles", i), bcnt, vt[i].lat - 1);
        end

        for (int i = 0; i < 40; i++) begin
            rdiv = 1'($urandom_range(0, 1));
            runs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: rb = -$urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            model(rdiv, runs, ra, rb, eh, el, ed);
            run_op(rdiv ? ALU_DIV : ALU_MUL, runs, ra, rb, lat, bcnt);
            check($sformatf("rand%0d_hilo", i), {hi, lo}, {eh, el});
            check($sformatf("rand%0d_flags", i), {div_by_zero, Zero}, {ed, el == 0});
            check($sformatf("rand%0d_latency", i), lat, (rdiv && rb == 0) ? 1 : 34);
        end

        // Non-MUL/DIV opcode is never accepted.
        @(negedge clk);
        ALUop = ALU_ADD; ifunsigned = 1'b1; A = 32'd3; B = 32'd4; start = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || done) bad++;
        end
        start = 1'b0;
        check("no_accept_add", bad, 0);

        // Start held through the whole op, operands scrambled while busy.
        @(negedge clk);
        ALUop = ALU_MUL; ifunsigned = 1'b1; A = 32'd3; B = 32'd4; start = 1'b1;
        dn = 0; seen = 0; h = '0; l = '0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (seen != 0) start = 1'b0;
            if (done) begin
                dn++; h = hi; l = lo; seen = 1;
            end else if (seen == 0) begin
                A = $urandom; B = $urandom;
            end
        end
        check("held_start_done_count", dn, 1);
        check("held_start_result", {h, l}, {32'd0, 32'd12});

        // Flush in CALC leaves results untouched and produces no done.
        @(negedge clk);
        ALUop = ALU_MUL; ifunsigned = 1'b1; A = 32'd7; B = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_drop", busy, 0);
        dn = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("flush_no_done", dn, 0);
        check("flush_hilo_kept", {hi, lo}, {32'd0, 32'd12});

        // Start together with flush in IDLE is not accepted.
        @(negedge clk);
        ALUop = ALU_MUL; A = 32'd5; B = 32'd5; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("flush_start_idle", {busy, done}, 2'b00);
        start = 1'b0; flush = 1'b0;

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        ALUop = ALU_MUL; ifunsigned = 1'b1; A = 32'hFFFF; B = 32'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_ctrl", {busy, done, div_by_zero, Zero}, 4'b0001);
        check("async_reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("async_reset_discard", dn, 0);

        run_op(ALU_MUL, 1'b0, 32'hFFFFFFFA, 32'd7, lat, bcnt);
        check("post_reset_mul", {hi, lo}, 64'hFFFFFFFF_FFFFFFD6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
